// File: rtl/event_encoder.sv
// Rising-edge event capture with a pending bitmap, presented highest-index-first
// as a binary code over a valid/ready handshake.
module event_encoder #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  pending,
  output logic              overflow,
  input  logic              ovf_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'b01,
    PRESENT = 2'b10
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_in_q;
  logic [WIDTH-1:0]    r_pending;
  logic [CODE_W-1:0]   r_code;
  logic                r_overflow;

  logic [WIDTH-1:0]    w_rise;
  logic                w_accept;
  logic [WIDTH-1:0]    w_clr_vec;
  logic [WIDTH-1:0]    w_rem;
  logic                w_load;
  logic [CODE_W-1:0]   w_code_nxt;
  logic                w_valid;

  function automatic logic [CODE_W-1:0] f_highest(input logic [WIDTH-1:0] v);
    f_highest = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) f_highest = CODE_W'(i);
    end
  endfunction

  assign w_rise    = in & ~r_in_q;
  assign w_accept  = w_valid & out_ready;
  assign w_clr_vec = w_accept ? (WIDTH'(1) << r_code) : '0;
  // Remaining work uses the registered bitmap; same-cycle rises are seen next cycle.
  assign w_rem     = r_pending & ~w_clr_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_code_nxt  = r_code;
    case (r_state)
      IDLE: begin
        if (r_pending != '0) begin
          w_state_nxt = PRESENT;
          w_load      = 1'b1;
          w_code_nxt  = f_highest(r_pending);
        end
      end
      PRESENT: begin
        if (w_accept) begin
          if (w_rem != '0) begin
            w_load     = 1'b1;
            w_code_nxt = f_highest(w_rem);
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_valid = (r_state == PRESENT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q     <= '0;
      r_pending  <= '0;
      r_code     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_in_q    <= in;
      r_pending <= w_rem | w_rise;
      if (w_load) r_code <= w_code_nxt;
      if (|(w_rise & r_pending & ~w_clr_vec)) r_overflow <= 1'b1;
      else if (ovf_clr)                        r_overflow <= 1'b0;
    end
  end

  assign out_code  = r_code;
  assign out_valid = w_valid;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_event_encoder.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model of the event encoder.
module tb_event_encoder;
  localparam int WIDTH  = 8;
  localparam int CODE_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  in;
  logic [CODE_W-1:0] out_code;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  pending;
  logic              overflow;
  logic              ovf_clr;

  int total = 0;
  int bad   = 0;

  // model state
  bit [WIDTH-1:0]  m_prev_in;
  bit [WIDTH-1:0]  m_pend;
  bit              m_valid;
  int              m_code;
  bit              m_ovf;

  event_encoder #(.WIDTH(WIDTH), .CODE_W(CODE_W)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .out_code(out_code), .out_valid(out_valid),
    .out_ready(out_ready), .pending(pending), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int top_index(input bit [WIDTH-1:0] v);
    for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev_in = '0; m_pend = '0; m_valid = 0; m_code = 0; m_ovf = 0;
  endtask

  // Advance the model by one clock using the inputs applied during this cycle.
  task automatic model_clock();
    bit [WIDTH-1:0] rise, taken, left;
    bit acc;
    rise  = in & ~m_prev_in;
    acc   = m_valid && out_ready;
    taken = '0;
    if (acc) taken[m_code] = 1'b1;
    left  = m_pend & ~taken;
    if ((rise & m_pend & ~taken) != '0) m_ovf = 1;
    else if (ovf_clr)                   m_ovf = 0;
    if (!m_valid) begin
      if (m_pend != '0) begin m_valid = 1; m_code = top_index(m_pend); end
    end else if (acc) begin
      if (left != '0) m_code = top_index(left);
      else            m_valid = 0;
    end
    m_pend    = left | rise;
    m_prev_in = in;
  endtask

  task automatic compare_all();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_code",  {29'd0, out_code},  m_code);
    chk("pending",   {24'd0, pending},   {24'd0, m_pend});
    chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; in = 8'hFF; out_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #20;
    chk("rst_valid",    {31'd0, out_valid}, 0);
    chk("rst_pending",  {24'd0, pending},   0);
    chk("rst_overflow", {31'd0, overflow},  0);
    chk("rst_code",     {29'd0, out_code},  0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // lines high at reset release
    step();
    chk("rel_pending", {24'd0, pending}, 32'hFF);
    chk("rel_valid0",  {31'd0, out_valid}, 0);
    step();
    chk("rel_valid1", {31'd0, out_valid}, 1);
    chk("rel_code7",  {29'd0, out_code}, 7);
    in = 8'h00; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("drain_idle", {31'd0, out_valid}, 0);

    // single event
    in = 8'h20; step();
    chk("single_pend", {24'd0, pending}, 32'h20);
    in = 8'h00; step();
    chk("single_valid", {31'd0, out_valid}, 1);
    chk("single_code",  {29'd0, out_code}, 5);
    step();
    chk("single_done",  {31'd0, out_valid}, 0);
    chk("single_clear", {24'd0, pending}, 0);

    // priority and back-to-back
    in = 8'h4A; step();
    in = 8'h00; step();
    chk("b2b_code6", {29'd0, out_code}, 6);
    step();
    chk("b2b_code3", {29'd0, out_code}, 3);
    step();
    chk("b2b_code1", {29'd0, out_code}, 1);
    chk("b2b_valid", {31'd0, out_valid}, 1);
    step();
    chk("b2b_end", {31'd0, out_valid}, 0);

    // stability, no preemption
    out_ready = 1'b0;
    in = 8'h04; step();
    in = 8'h00; step();
    chk("hold_code2a", {29'd0, out_code}, 2);
    in = 8'h80; step();
    chk("hold_code2b", {29'd0, out_code}, 2);
    chk("hold_pend",   {24'd0, pending}, 32'h84);
    in = 8'h00; step(); step();
    chk("hold_code2c", {29'd0, out_code}, 2);
    out_ready = 1'b1; step();
    chk("hold_code7", {29'd0, out_code}, 7);
    chk("hold_valid", {31'd0, out_valid}, 1);
    step();

    // overflow
    out_ready = 1'b0;
    in = 8'h10; step();
    in = 8'h00; step();
    chk("ovf_code4", {29'd0, out_code}, 4);
    chk("ovf_none",  {31'd0, overflow}, 0);
    in = 8'h10; step();
    chk("ovf_set", {31'd0, overflow}, 1);
    in = 8'h00; ovf_clr = 1'b1; step();
    chk("ovf_clr", {31'd0, overflow}, 0);
    ovf_clr = 1'b0;
    in = 8'h10; out_ready = 1'b1; step();
    chk("ovf_coinc_flag", {31'd0, overflow}, 0);
    chk("ovf_coinc_pend", {31'd0, pending[4]}, 1);
    in = 8'h00; step(); step(); step();

    // async reset mid-operation
    out_ready = 1'b0;
    in = 8'h0A; step();
    in = 8'h00; step();
    chk("ar_pend",  {24'd0, pending}, 32'h0A);
    chk("ar_valid", {31'd0, out_valid}, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_valid0", {31'd0, out_valid}, 0);
    chk("ar_pend0",  {24'd0, pending}, 0);
    chk("ar_code0",  {29'd0, out_code}, 0);
    chk("ar_ovf0",   {31'd0, overflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      in        = WIDTH'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/event_encoder.md
Name: event_encoder

Overview:
- Sequential 8-to-3 event encoder; the inverse direction of the team's one-hot decoder.
- Captures rising edges on up to WIDTH event lines into a pending register.
- Presents the highest-index pending event as a binary code over a valid/ready handshake.
- Clears each event once it is accepted. Sits between peripheral event sources and the control logic that consumes event codes.

Parameters:
- WIDTH, 8: number of event input lines; must be ≥2.
- CODE_W, $clog2(WIDTH) (3 at default): width of the binary output code.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  event request lines; level inputs, synchronous to clk.
- out_code  output  CODE_W  binary index of the presented event.
- out_valid  output  1  out_code holds a valid event.
- out_ready  input  1  consumer accepts out_code this cycle.
- pending  output  WIDTH  registered pending-event bitmap (status/debug).
- overflow  output  1  sticky flag: an event was re-raised while already pending.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n low, asynchronous): in_q=0, pending=0, out_code=0, out_valid=0, overflow=0, state=IDLE. All outputs are held at these values until the first clk edge with rst_n high.
- Edge detect:
  - in_q registers in every cycle.
  - rise = in & ~in_q.
  - A line already high when reset releases produces one rise on the first active edge.
- Handshake: accept = out_valid & out_ready.
  - clr_vec = onehot(out_code) when accept, else 0.
- Pending update: pending <= (pending & ~clr_vec) | rise.
  - A rise on the bit being cleared in the same cycle wins: the bit stays set, and overflow is not set.
- Overflow:
  - Set when any bit has rise=1, pending=1 and clr_vec=0.
  - Otherwise cleared when ovf_clr=1. Set takes priority over ovf_clr in the same cycle.
  - Holds its value otherwise.
- Priority: highest set index wins (bit WIDTH-1 highest, bit 0 lowest).
- FSM, IDLE:
  - out_valid=0.
  - If registered pending != 0: load out_code = highest set index of pending, set out_valid=1, go to PRESENT.
  - Otherwise stay in IDLE.
- FSM, PRESENT:
  - out_valid=1. out_code and out_valid are held stable until accept.
  - No preemption: a higher-priority event arriving meanwhile waits.
  - On accept, compute rem = pending & ~clr_vec, using the registered pending, excluding same-cycle rises.
  - If rem != 0: load out_code = highest index of rem and stay in PRESENT. This is back-to-back presentation with no bubble.
  - Else: out_valid=0, go to IDLE. out_code keeps its last value.
- Latency, with in[i] first sampled high at edge k and the FSM idle:
  - pending[i]=1 after edge k.
  - out_valid=1 and out_code=i after edge k+1.
- A level held high produces exactly one event. It needs a low→high transition to re-trigger.
- out_ready while out_valid=0 is ignored.
- Reset mid-operation drops all pending events immediately; the overflow flag is lost.
- The FSM has only IDLE and PRESENT. Any illegal state encoding returns to IDLE.

Test Plan:
- Reset: hold rst_n=0 with in=8'hFF → out_valid=0, pending=0, overflow=0. Release → pending=8'hFF after the first edge, out_valid=1 with out_code=7 one edge later.
- Single event, ready high: pulse in[5] for one cycle → out_code=3'd5 with out_valid=1 for exactly one cycle, then pending=0, state IDLE.
- Priority and back-to-back: rise on in[1], in[6], in[3] in the same cycle, out_ready=1 → consecutive cycles present codes 6, 3, 1, then out_valid falls.
- Stability and no preemption: out_ready=0 while code 2 is presented; raise in[7] → out_code stays 2 until out_ready=1. Next cycle presents 7.
- Overflow: in[4] pending and not accepted; toggle in[4] low→high → overflow=1. Pulse ovf_clr → overflow=0. Re-raise coincident with acceptance of code 4 → overflow stays 0 and pending[4] stays set.
- Async reset mid-operation: drop rst_n between clock edges while out_valid=1 and pending=8'h0A → outputs go to 0 immediately, without a clock edge.
